serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B - bi, one bit per clock, LSB first.
// Latency WIDTH cycles from accepted start to done; start is ignored while busy.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             bi,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] DIFF,
    output logic             bo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] r_sr;
    logic             br;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] diff_q;
    logic             bo_q;

    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             br_nxt;
    logic             last_bit;
    logic             accept;
    logic [WIDTH-1:0] r_nxt;

    // Single full-subtractor cell working on the current LSBs
    assign a_bit    = a_sr[0];
    assign b_bit    = b_sr[0];
    assign d_bit    = a_bit ^ b_bit ^ br;
    assign br_nxt   = (~a_bit & b_bit) | (~a_bit & br) | (b_bit & br);
    assign last_bit = (cnt == CW'(WIDTH - 1));
    assign accept   = start && (state != SHIFT);
    assign r_nxt    = {d_bit, r_sr[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = start ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == SHIFT);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            r_sr   <= '0;
            br     <= 1'b0;
            cnt    <= '0;
            diff_q <= '0;
            bo_q   <= 1'b0;
        end else if (accept) begin
            a_sr <= A;
            b_sr <= B;
            br   <= bi;
            cnt  <= '0;
        end else if (state == SHIFT) begin
            a_sr <= a_sr >> 1;
            b_sr <= b_sr >> 1;
            r_sr <= r_nxt;
            br   <= br_nxt;
            cnt  <= cnt + 1'b1;
            // The final bit lands straight in the result, so DIFF/bo update with done
            if (last_bit) begin
                diff_q <= r_nxt;
                bo_q   <= br_nxt;
            end
        end
    end

    assign DIFF = diff_q;
    assign bo   = bo_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor at WIDTH=4 and WIDTH=16.
// Expected results and completion cycles are queued at acceptance; monitors pop on done.
module tb_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    logic        start4 = 1'b0, bi4 = 1'b0, busy4, done4, bo4;
    logic [3:0]  a4 = '0, b4 = '0, diff4;
    logic        start16 = 1'b0, bi16 = 1'b0, busy16, done16, bo16;
    logic [15:0] a16 = '0, b16 = '0, diff16;

    typedef struct {
        logic [16:0] val;
        int          cyc;
    } exp_t;
    exp_t q4[$];
    exp_t q16[$];

    serial_subtractor #(.WIDTH(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .bi(bi4),
        .busy(busy4), .done(done4), .DIFF(diff4), .bo(bo4)
    );

    serial_subtractor #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .A(a16), .B(b16), .bi(bi16),
        .busy(busy16), .done(done16), .DIFF(diff16), .bo(bo16)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && done4 === 1'b1) begin
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done4_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q4.pop_front();
                chk("res4", {27'd0, bo4, diff4}, {15'd0, e.val});
                chk("lat4", cyc, e.cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && done16 === 1'b1) begin
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done16_unexpected: got done=1 expected no pending op (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = q16.pop_front();
                chk("res16", {15'd0, bo16, diff16}, {15'd0, e.val});
                chk("lat16", cyc, e.cyc);
            end
        end
    end

    // Waits for busy low, offers the operands, and queues the expectation on acceptance.
    task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi,
                       input logic [4:0] exp, input bit push, input bit hold);
        int n = 0;
        @(negedge clk);
        while (busy4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("op4_wait_timeout", busy4, 1'b0);
        a4 = a; b4 = b; bi4 = bi; start4 = 1'b1;
        @(posedge clk);
        #1;
        if (push) q4.push_back('{val: {12'd0, exp}, cyc: cyc + 4});
        @(negedge clk);
        chk("busy4_after_accept", busy4, 1'b1);
        if (!hold) start4 = 1'b0;
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi);
        int n = 0;
        logic [16:0] exp;
        exp = {1'b0, a} - {1'b0, b} - {16'd0, bi};
        @(negedge clk);
        while (busy16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("op16_wait_timeout", busy16, 1'b0);
        a16 = a; b16 = b; bi16 = bi; start16 = 1'b1;
        @(posedge clk);
        #1;
        q16.push_back('{val: exp, cyc: cyc + 16});
        @(negedge clk);
        start16 = 1'b0;
    endtask

    initial begin
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy4", busy4, 1'b0);
        chk("rst_done4", done4, 1'b0);
        chk("rst_out4", {bo4, diff4}, 5'd0);
        chk("rst_out16", {bo16, diff16}, 17'd0);
        rst = 1'b0;

        // Hand-computed directed cases
        op4(4'd5,  4'd3,  1'b0, 5'b0_0010, 1, 0);
        op4(4'd3,  4'd5,  1'b0, 5'b1_1110, 1, 0);
        op4(4'd0,  4'd0,  1'b1, 5'b1_1111, 1, 0);
        op4(4'd15, 4'd15, 1'b0, 5'b0_0000, 1, 0);
        op4(4'd15, 4'd0,  1'b1, 5'b0_1110, 1, 0);

        // start during SHIFT with other operands is ignored
        op4(4'd9, 4'd4, 1'b0, 5'b0_0101, 1, 0);
        a4 = 4'd1; b4 = 4'd7; bi4 = 1'b1; start4 = 1'b1;
        repeat (2) @(negedge clk);
        start4 = 1'b0;

        // start held high, operands change each op
        op4(4'd12, 4'd7, 1'b0, 5'b0_0101, 1, 1);
        op4(4'd2,  4'd9, 1'b1, 5'b1_1000, 1, 1);
        op4(4'd8,  4'd8, 1'b1, 5'b1_1111, 1, 1);
        op4(4'd6,  4'd1, 1'b1, 5'b0_0100, 1, 0);

        // Reset two cycles into an operation aborts it
        op4(4'd10, 4'd2, 1'b0, 5'b0_1000, 1, 0);
        op4(4'd7, 4'd1, 1'b0, 5'd0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy4", busy4, 1'b0);
        chk("abort_done4", done4, 1'b0);
        chk("abort_out4", {bo4, diff4}, 5'd0);
        @(negedge clk);
        rst = 1'b0;
        op4(4'd11, 4'd6, 1'b0, 5'b0_0101, 1, 0);

        // Exhaustive sweep at WIDTH=4
        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int c = 0; c < 2; c++) begin
                    logic [4:0] e;
                    e = {1'b0, 4'(a)} - {1'b0, 4'(b)} - 5'(c);
                    op4(4'(a), 4'(b), 1'(c), e, 1, 0);
                end

        // Random and corner operands at WIDTH=16
        op16(16'h0000, 16'h0000, 1'b1);
        op16(16'hFFFF, 16'hFFFF, 1'b0);
        op16(16'h0000, 16'hFFFF, 1'b1);
        for (int i = 0; i < 1000; i++)
            op16(16'($urandom), 16'($urandom), 1'($urandom));

        n = 0;
        while ((q4.size() != 0 || q16.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        chk("q4_drained", q4.size(), 0);
        chk("q16_drained", q16.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
